// File: rtl/riscv_lsu.sv
// Load/store unit: one MEM-stage access at a time over a req/gnt/rvalid data bus.
// Builds byte enables and lane-replicated store data, and extends load data.
module riscv_lsu #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WORD_SIZE-1:0]  req_wdata_i,
  output logic                  stall_o,
  output logic [WORD_SIZE-1:0]  rdata_o,
  output logic                  rdata_valid_o,
  output logic                  misaligned_o,
  output logic                  err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [3:0]            bus_be_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [WORD_SIZE-1:0]  bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [WORD_SIZE-1:0]  bus_rdata_i,
  input  logic                  bus_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            off_q, off_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [3:0]            bus_be_q, bus_be_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [WORD_SIZE-1:0]  bus_wdata_q, bus_wdata_d;
  logic [WORD_SIZE-1:0]  rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic                  misaligned_q, misaligned_d;
  logic                  err_q, err_d;

  logic                  misaligned_s;
  logic [3:0]            be_s;
  logic [WORD_SIZE-1:0]  wdata_s;
  logic [7:0]            byte_s;
  logic [15:0]           half_s;
  logic [WORD_SIZE-1:0]  load_ext_s;

  // Request decode: alignment check, byte enables and replicated store lanes.
  always_comb begin
    misaligned_s = 1'b0;
    be_s         = 4'b1111;
    wdata_s      = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        be_s    = 4'b0001 << req_addr_i[1:0];
        wdata_s = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned_s = req_addr_i[0];
        be_s         = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_s      = {2{req_wdata_i[15:0]}};
      end
      2'b10: begin
        misaligned_s = (req_addr_i[1:0] != 2'b00);
      end
      default: begin
        misaligned_s = 1'b1;
      end
    endcase
    if (!req_we_i) begin
      be_s = 4'b1111;
    end else begin
      be_s = be_s;
    end
  end

  // Load lane selection and sign/zero extension of the returning bus word.
  always_comb begin
    byte_s     = bus_rdata_i[{off_q, 3'b000} +: 8];
    half_s     = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    load_ext_s = bus_rdata_i;
    case (size_q)
      2'b00:   load_ext_s = {{24{~uns_q & byte_s[7]}}, byte_s};
      2'b01:   load_ext_s = {{16{~uns_q & half_s[15]}}, half_s};
      default: load_ext_s = bus_rdata_i;
    endcase
  end

  // Next-state and registered-output logic of the access FSM.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    off_d         = off_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_be_d      = bus_be_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    misaligned_d  = 1'b0;
    err_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d   = req_we_i;
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          off_d  = req_addr_i[1:0];
          if (misaligned_s) begin
            state_d      = RESP;
            misaligned_d = 1'b1;
          end else begin
            state_d     = REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we_i;
            bus_be_d    = be_s;
            bus_addr_d  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            bus_wdata_d = wdata_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          state_d     = WAIT;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_be_d    = 4'b0000;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          state_d = RESP;
          if (bus_err_i) begin
            err_d = 1'b1;
          end else if (!we_q) begin
            rdata_valid_d = 1'b1;
            rdata_d       = load_ext_s;
          end else begin
            rdata_valid_d = 1'b0;
          end
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      off_q         <= 2'b00;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_be_q      <= 4'b0000;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      off_q         <= off_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_be_q      <= bus_be_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      misaligned_q  <= misaligned_d;
      err_q         <= err_d;
    end
  end

  // Stall is combinational so the accepting cycle already holds the pipeline.
  assign stall_o       = ~rst_i & (state_q != RESP) & ((state_q != IDLE) | req_valid_i);
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign misaligned_o  = misaligned_q;
  assign err_o         = err_q;
  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = bus_we_q;
  assign bus_be_o      = bus_be_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed scenarios plus randomized accesses against a
// transaction-level reference model of lanes, extension and response pulses.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misaligned;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_err = 1'b0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rdata = 32'h0;

  riscv_lsu #(.WORD_SIZE(32), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .stall_o(stall), .rdata_o(rdata),
    .rdata_valid_o(rdata_valid), .misaligned_o(misaligned), .err_o(err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt),
    .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // One access from the IDLE cycle through RESP; leaves time at posedge+1 of the next cycle.
  task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int gd, input int rd, input logic [31:0] rdat,
                            input logic berr);
    logic [1:0]  a;
    logic        mis;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] shifted;
    logic [31:0] v;
    a   = addr[1:0];
    mis = (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a != 2'd0);
    if (!we) ebe = 4'hF;
    else if (size == 2'd0) ebe = 4'(1 << a);
    else if (size == 2'd1) ebe = a[1] ? 4'hC : 4'h3;
    else ebe = 4'hF;
    if (size == 2'd0) ewd = {24'h0, wdata[7:0]} * 32'h01010101;
    else if (size == 2'd1) ewd = {16'h0, wdata[15:0]} * 32'h00010001;
    else ewd = wdata;
    shifted = rdat >> (8 * a);
    if (size == 2'd0) begin
      v = shifted & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = shifted & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = rdat;
    end

    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL accept_stall: got %b want 1", stall); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL accept_busreq: got %b want 0", bus_req); end
    total++; if ({rdata_valid, misaligned, err} !== 3'b000) begin bad++; $display("FAIL idle_pulses: got %b want 000", {rdata_valid, misaligned, err}); end
    @(posedge clk); #1;

    if (!mis) begin
      for (int i = 0; i <= gd; i++) begin
        bus_gnt = (i == gd);
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL req_phase: got req=%b stall=%b want 1 1", bus_req, stall); end
        total++; if (bus_addr !== {addr[31:2], 2'b00}) begin bad++; $display("FAIL bus_addr: got %h want %h", bus_addr, {addr[31:2], 2'b00}); end
        total++; if (bus_be !== ebe || bus_we !== we) begin bad++; $display("FAIL bus_be_we: got %b/%b want %b/%b", bus_be, bus_we, ebe, we); end
        if (we) begin
          total++; if (bus_wdata !== ewd) begin bad++; $display("FAIL bus_wdata: got %h want %h", bus_wdata, ewd); end
        end
        @(posedge clk); #1;
      end
      bus_gnt = 1'b0;
      for (int i = 0; i <= rd; i++) begin
        bus_rvalid = (i == rd); bus_rdata = rdat; bus_err = berr;
        @(negedge clk);
        total++; if (bus_req !== 1'b0 || stall !== 1'b1 || rdata_valid !== 1'b0) begin bad++; $display("FAIL wait_phase: got req=%b stall=%b rv=%b want 0 1 0", bus_req, stall, rdata_valid); end
        @(posedge clk); #1;
      end
      bus_rvalid = 1'b0; bus_err = 1'b0;
      if (!we && !berr) exp_rdata = v;
    end

    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL resp_stall: got %b want 0", stall); end
    total++; if ({rdata_valid, misaligned, err} !== {!mis && !we && !berr, mis, !mis && berr}) begin
      bad++; $display("FAIL resp_pulses: got %b want %b", {rdata_valid, misaligned, err}, {!mis && !we && !berr, mis, !mis && berr});
    end
    total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL resp_rdata: got %h want %h", rdata, exp_rdata); end
    if (mis) begin
      total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL mis_busreq: got %b want 0", bus_req); end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    total++; if ({rdata_valid, misaligned, err, stall, bus_req} !== 5'b0) begin bad++; $display("FAIL idle: got %b want 00000", {rdata_valid, misaligned, err, stall, bus_req}); end
    total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL idle_rdata: got %h want %h", rdata, exp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({stall, rdata_valid, misaligned, err, bus_req, bus_we} !== 6'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 000000", {stall, rdata_valid, misaligned, err, bus_req, bus_we}); end
    total++; if ({bus_be, bus_addr, bus_wdata, rdata} !== 100'b0) begin bad++; $display("FAIL reset_data: got %h want 0", {bus_be, bus_addr, bus_wdata, rdata}); end
    rst = 1'b0;
    exp_rdata = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2, 1, 32'hDEADBEEF, 1'b0);
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_result: got %h want deadbeef", rdata); end
    idle_cycle();
  endtask

  task automatic test_subword_loads();
    run_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 1'b0);
    total++; if (rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_result: got %h want ffffff80", rdata); end
    run_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 0, 32'h80FF0000, 1'b0);
    total++; if (rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_result: got %h want 00000080", rdata); end
    run_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0, 2, 32'h80FF0000, 1'b0);
    total++; if (rdata !== 32'h000080FF) begin bad++; $display("FAIL lhu_result: got %h want 000080ff", rdata); end
    idle_cycle();
  endtask

  task automatic test_store_half();
    run_access(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 1, 1, 32'h0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 0, 32'h0, 1'b0);
    run_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0);
    run_access(1'b1, 2'd1, 1'b0, 32'h101, 32'h55AA, 0, 0, 32'h0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h300;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_wait_stall: got %b want 1", stall); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if ({stall, rdata_valid, misaligned, err, bus_req, bus_be, bus_addr, rdata} !== 73'b0) begin
      bad++; $display("FAIL rst_mid_outputs: got %h want 0", {stall, rdata_valid, misaligned, err, bus_req, bus_be, bus_addr, rdata});
    end
    exp_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    idle_cycle();
  endtask

  task automatic test_bus_error();
    run_access(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, 0, 32'h0BADF00D, 1'b0);
    run_access(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 1, 1, 32'hCAFEF00D, 1'b1);
    total++; if (rdata !== 32'h0BADF00D) begin bad++; $display("FAIL err_rdata_hold: got %h want 0badf00d", rdata); end
    run_access(1'b0, 2'd1, 1'b0, 32'h406, 32'h0, 0, 0, 32'h9234_0000, 1'b0);
    run_access(1'b0, 2'd0, 1'b1, 32'h401, 32'h0, 0, 0, 32'h0000_C300, 1'b0);
    total++; if (rdata !== 32'h000000C3) begin bad++; $display("FAIL b2b_result: got %h want 000000c3", rdata); end
    idle_cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_loads();
    test_store_half();
    test_misaligned();
    test_reset_mid();
    test_bus_error();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
